// File: rtl/ps_frame_scheduler.sv
// ps_frame_scheduler: round-robin arbiter and frame timer in front of a shared
// LSB-first parallel-to-serial trigger shift register. A winner's WIDTH-bit
// word is captured at grant, presented on sr_data with a one-cycle sr_load
// strobe, then framed by frame_en for WIDTH cycles and followed by GAP idle
// cycles before the next arbitration.
// Optional feature macro: PS_SCHED_ABORT_EN (adds abort input / aborted output).
module ps_frame_scheduler #(
  parameter int WIDTH = 100,
  parameter int NREQ  = 4,
  parameter int GAP   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    sr_load,
  output logic [WIDTH-1:0]        sr_data,
  output logic                    frame_en,
  output logic                    busy
`ifdef PS_SCHED_ABORT_EN
  ,
  input  logic                    abort,
  output logic                    aborted
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [WIDTH-1:0]  sr_data_q, sr_data_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
`ifdef PS_SCHED_ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  logic              req_any;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     idx;
  logic [WIDTH-1:0]  winner_data;

  // Round-robin search: first set request starting just after the last winner.
  always_comb begin
    req_any = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      if (!req_any && req[idx]) begin
        req_any = 1'b1;
        winner  = idx;
      end
    end
    winner_data = req_data[int'(winner)*WIDTH +: WIDTH];
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    sr_data_d = sr_data_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d   = S_LOAD;
          grant_d   = winner;
          last_d    = winner;
          sr_data_d = winner_data;
        end
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        bit_cnt_d = '0;
      end
      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d   = (GAP > 0) ? S_GAP : S_IDLE;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PS_SCHED_ABORT_EN
    aborted_d = 1'b0;
    if (abort && (state_q == S_LOAD || state_q == S_SHIFT)) begin
      state_d   = (GAP > 0) ? S_GAP : S_IDLE;
      gap_cnt_d = '0;
      aborted_d = 1'b1;
    end
`endif
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Arbitration pointer, grant, captured frame and counters.
  // NOTE: sr_data is a single register with a defined reset value, not a
  // memory array, so it is cleared by reset like any other control flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= IW'(NREQ - 1);
      grant_q   <= '0;
      sr_data_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
`ifdef PS_SCHED_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      last_q    <= last_d;
      grant_q   <= grant_d;
      sr_data_q <= sr_data_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef PS_SCHED_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Moore outputs decoded from state, so they fall as soon as rst resets state.
  // NOTE: every output gets a default first so no path through the case
  // leaves a variable unassigned (which would infer a latch).
  always_comb begin
    ack      = '0;
    sr_load  = 1'b0;
    frame_en = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_LOAD: begin
        sr_load      = 1'b1;
        busy         = 1'b1;
        ack[grant_q] = 1'b1;
      end
      S_SHIFT: begin
        frame_en = 1'b1;
        busy     = 1'b1;
      end
      S_GAP:   busy = 1'b1;
      default: ;
    endcase
  end

  assign grant_id = grant_q;
  assign sr_data  = sr_data_q;
`ifdef PS_SCHED_ABORT_EN
  assign aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_ps_frame_scheduler.sv
// Directed bench for ps_frame_scheduler: a GAP=4 instance for arbitration,
// timing, reset and abort, and a GAP=0 instance for back-to-back framing.
// Expected grants are queued when requests are driven and popped at sr_load.
module tb_ps_frame_scheduler;

  localparam int WIDTH = 100;
  localparam int NREQ  = 4;
  localparam int IW    = $clog2(NREQ);

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req,  req2;
  logic [NREQ*WIDTH-1:0] req_data, req_data2;
  logic [NREQ-1:0]       ack,  ack2;
  logic [IW-1:0]         grant_id, grant_id2;
  logic                  sr_load, sr_load2;
  logic [WIDTH-1:0]      sr_data, sr_data2;
  logic                  frame_en, frame_en2;
  logic                  busy, busy2;
`ifdef PS_SCHED_ABORT_EN
  logic                  abort, abort2;
  logic                  aborted, aborted2;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  ps_frame_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .sr_load(sr_load), .sr_data(sr_data),
    .frame_en(frame_en), .busy(busy)
`ifdef PS_SCHED_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  ps_frame_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .ack(ack2),
    .grant_id(grant_id2), .sr_load(sr_load2), .sr_data(sr_data2),
    .frame_en(frame_en2), .busy(busy2)
`ifdef PS_SCHED_ABORT_EN
    , .abort(abort2), .aborted(aborted2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] word(input int i);
    logic [3:0] nib;
    nib = 4'(i + 10);
    return {25{nib}};
  endfunction

  // Step until the selected DUT strobes sr_load, then pop and compare.
  task automatic wait_load(input bit alt, input int budget, input string tag,
                           output int at);
    int               n = 0;
    logic             ld, bz, fe;
    logic [NREQ-1:0]  ak;
    logic [IW-1:0]    gid;
    logic [WIDTH-1:0] sd;
    exp_t             e;
    tick();
    while (!(alt ? sr_load2 : sr_load) && n < budget) begin
      tick();
      n++;
    end
    ld  = alt ? sr_load2  : sr_load;
    ak  = alt ? ack2      : ack;
    gid = alt ? grant_id2 : grant_id;
    sd  = alt ? sr_data2  : sr_data;
    bz  = alt ? busy2     : busy;
    fe  = alt ? frame_en2 : frame_en;
    at  = -1;
    check({tag, "_load_seen"}, ld, 1);
    if (!ld) return;
    at = cyc;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_underflow"}, sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_ack"},      ak,  NREQ'(1) << e.id);
    check({tag, "_grant_id"}, gid, e.id);
    check({tag, "_sr_data"},  sd,  e.data);
    check({tag, "_busy"},     bz,  1);
    check({tag, "_frame_en"}, fe,  0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int at0, at1, prev;
    int fe_cnt, fe_first, fe_last, busy_low, ack_cnt, load_cnt;

    rst       = 1'b1;
    req       = '0;
    req2      = '0;
    req_data  = '0;
    req_data2 = '0;
`ifdef PS_SCHED_ABORT_EN
    abort     = 1'b0;
    abort2    = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) req_data2[i*WIDTH +: WIDTH] = word(i + 4);

    // Reset state, during and after reset.
    tick();
    check("rst_ack",      ack,      0);
    check("rst_sr_load",  sr_load,  0);
    check("rst_frame_en", frame_en, 0);
    check("rst_busy",     busy,     0);
    check("rst_grant_id", grant_id, 0);
    check("rst_sr_data",  sr_data,  0);
`ifdef PS_SCHED_ABORT_EN
    check("rst_aborted",  aborted,  0);
`endif
    rst = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_ack",  ack,  0);

    // 1: single request, full frame timing.
    req_data[0 +: WIDTH] = 100'h5;
    req = 4'b0001;
    sb_q.push_back('{0, 100'h5});
    wait_load(0, 10, "t1", at0);
    req = '0;
    fe_cnt = 0; fe_first = -1; fe_last = -1; busy_low = -1; ack_cnt = 0;
    for (int off = 1; off <= 110; off++) begin
      tick();
      if (frame_en) begin
        fe_cnt++;
        if (fe_first < 0) fe_first = off;
        fe_last = off;
      end
      if (!busy && busy_low < 0) busy_low = off;
      if (ack != 0) ack_cnt++;
    end
    check("t1_fe_count",  fe_cnt,   100);
    check("t1_fe_first",  fe_first, 1);
    check("t1_fe_last",   fe_last,  100);
    check("t1_busy_low",  busy_low, 105);
    check("t1_no_reack",  ack_cnt,  0);

    // 2: all four held, round-robin order and 106-cycle spacing.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = word(i);
    req = 4'b1111;
    sb_q.push_back('{0, word(0)});
    sb_q.push_back('{1, word(1)});
    sb_q.push_back('{2, word(2)});
    sb_q.push_back('{3, word(3)});
    sb_q.push_back('{0, word(0)});
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_load(0, 300, $sformatf("t2_%0d", k), at0);
      if (k > 0) check($sformatf("t2_spacing%0d", k), at0 - prev, 106);
      prev = at0;
    end
    req = '0;
    wait_idle("t2");

    // 3: reset mid-frame, then a fresh full frame to the same requester.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0100;
    sb_q.push_back('{2, word(2)});
    wait_load(0, 10, "t3a", at0);
    repeat (51) tick();
    check("t3_mid_frame_en", frame_en, 1);
    rst = 1'b1;
    #1;
    check("t3_async_frame_en", frame_en, 0);
    check("t3_async_busy",     busy,     0);
    check("t3_async_sr_load",  sr_load,  0);
    check("t3_async_ack",      ack,      0);
    check("t3_async_grant_id", grant_id, 0);
    check("t3_async_sr_data",  sr_data,  0);
    tick();
    rst = 1'b0;
    sb_q.push_back('{2, word(2)});
    wait_load(0, 10, "t3b", at0);
    req = '0;
    req_data[2*WIDTH +: WIDTH] = word(7);
    fe_cnt = 0;
    for (int off = 1; off <= 101; off++) begin
      tick();
      if (frame_en) fe_cnt++;
      if (off == 50) check("t3_sr_data_held", sr_data, word(2));
    end
    check("t3_fe_count", fe_cnt, 100);
    wait_idle("t3");

    // 4: requester 1 raised during shift and dropped in gap is never served.
    req = 4'b1000;
    sb_q.push_back('{3, word(3)});
    wait_load(0, 10, "t4", at0);
    req = '0;
    ack_cnt = 0; load_cnt = 0;
    for (int off = 1; off <= 140; off++) begin
      tick();
      if (ack != 0) ack_cnt++;
      if (sr_load)  load_cnt++;
      if (off == 20)  req[1] = 1'b1;
      if (off == 103) req[1] = 1'b0;
    end
    check("t4_no_ack",  ack_cnt,  0);
    check("t4_no_load", load_cnt, 0);
    check("t4_idle",    busy,     0);

    // 5: GAP=0 instance, two requesters held, 102-cycle spacing.
    req2 = 4'b0011;
    sb_q.push_back('{0, word(4)});
    sb_q.push_back('{1, word(5)});
    wait_load(1, 300, "t5a", at0);
    fe_cnt = 0;
    for (int off = 1; off <= 101; off++) begin
      tick();
      if (frame_en2) fe_cnt++;
    end
    check("t5_fe_count",    fe_cnt,    100);
    check("t5_idle_fe",     frame_en2, 0);
    check("t5_idle_busy",   busy2,     0);
    check("t5_idle_load",   sr_load2,  0);
    wait_load(1, 10, "t5b", at1);
    req2 = '0;
    check("t5_spacing", at1 - at0, 102);

`ifdef PS_SCHED_ABORT_EN
    // 6: abort at bit 10, gap, then re-arbitration of the held request.
    wait_idle("t6_pre");
    req = 4'b0010;
    sb_q.push_back('{1, word(1)});
    wait_load(0, 10, "t6a", at0);
    repeat (11) tick();
    check("t6_pre_abort_fe", frame_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_fe_drop",   frame_en, 0);
    check("t6_aborted",   aborted,  1);
    check("t6_busy_gap",  busy,     1);
    sb_q.push_back('{1, word(1)});
    tick();
    check("t6_aborted_pulse", aborted, 0);
    wait_load(0, 20, "t6b", at1);
    req = '0;
    check("t6_spacing", at1 - at0, 17);
`endif

    wait_idle("end");
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
